spectro_frame_engine: RTL

- Parametrised successor of the 15-channel spectrogram extractor.
- Counts pulses on NUM_CH filter-bank channels over fixed frames measured in RTC ticks.
- Snapshots all counts atomically at frame close into a shadow bank, then serialises a header plus every channel word on a 1-bit stream under sink flow control.
- Counting continues seamlessly while a frame is being shifted out; no separate reset pulse to the counters is needed.

---
 rtl/spectro_frame_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spectro_frame_engine.sv
// Frame-based multi-channel pulse counter with a flow-controlled serial dump.
// Optional even parity per field is enabled by defining SPECTRO_PARITY_EN.
module spectro_frame_engine #(
  parameter int NUM_CH      = 15,
  parameter int CNT_W       = 12,
  parameter int FRAME_TICKS = 60,
  parameter int FIDX_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic              rtc_tick,
  input  logic              shift_en,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              frame_start,
  output logic              busy,
  output logic              ovf_flag,
  output logic              overrun
);

`ifdef SPECTRO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int HDR_LEN  = FIDX_W + 1 + PAR;
  localparam int WORD_LEN = CNT_W + PAR;
  localparam int LEN      = HDR_LEN + NUM_CH * WORD_LEN;
  localparam int BIT_W    = $clog2(LEN);
  localparam int TICK_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  logic [NUM_CH:0]   r_s1, r_s2, r_s3;
  logic [NUM_CH:0]   w_ev;
  logic              w_rtc_ev, w_close, w_hit, w_take, w_fs_nxt;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [CNT_W-1:0]  w_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_shd [NUM_CH];
  logic [TICK_W-1:0] r_tick;
  logic [FIDX_W-1:0] r_fidx, r_hfidx;
  logic              r_hovf, r_ovf, r_ovr, r_fs;
  state_t            r_state, w_state_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [LEN-1:0]    w_stream;

  assign w_ev     = r_s2 & ~r_s3;
  assign w_rtc_ev = w_ev[NUM_CH];
  assign w_close  = w_rtc_ev && (r_tick == TICK_W'(FRAME_TICKS - 1));
  assign w_take   = (r_state != IDLE) && shift_en;

  // Two-flop synchroniser plus an edge-history flop for all inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= {rtc_tick, ch_in};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next counter values: close restarts from this cycle's event
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_nxt[i] = r_cnt[i];
      if (w_close)
        w_nxt[i] = w_ev[i] ? CNT_W'(1) : '0;
      else if (w_ev[i] && r_cnt[i] != MAX)
        w_nxt[i] = r_cnt[i] + CNT_W'(1);
      if (w_ev[i] && w_nxt[i] == MAX)
        w_hit = 1'b1;
    end
  end

  // Counters, frame timing, snapshot and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_shd[i] <= '0;
      end
      r_tick  <= '0;
      r_fidx  <= '0;
      r_hfidx <= '0;
      r_hovf  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        r_cnt[i] <= w_nxt[i];
      r_ovf <= w_close ? w_hit : (r_ovf | w_hit);
      if (w_rtc_ev)
        r_tick <= w_close ? '0 : r_tick + TICK_W'(1);
      if (w_close) begin
        r_fidx <= r_fidx + FIDX_W'(1);
        if (r_state == IDLE) begin
          for (int i = 0; i < NUM_CH; i++)
            r_shd[i] <= r_cnt[i];
          r_hfidx <= r_fidx;
          r_hovf  <= r_ovf;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  // Serialiser next state and bit pointer
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_fs_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_close) begin
          w_state_nxt = HEADER;
          w_bit_nxt   = '0;
          w_fs_nxt    = 1'b1;
        end
      end
      HEADER: begin
        if (w_take) begin
          w_bit_nxt = r_bit + BIT_W'(1);
          if (r_bit == BIT_W'(HDR_LEN - 1))
            w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_take) begin
          if (r_bit == BIT_W'(LEN - 1)) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_fs    <= w_fs_nxt;
    end
  end

  // Stream image, bit k is the k-th bit sent
  always_comb begin
    w_stream = '0;
    for (int k = 0; k < FIDX_W; k++)
      w_stream[k] = r_hfidx[FIDX_W-1-k];
    w_stream[FIDX_W] = r_hovf;
`ifdef SPECTRO_PARITY_EN
    w_stream[FIDX_W+1] = ^{r_hfidx, r_hovf};
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < CNT_W; b++)
        w_stream[HDR_LEN + c*WORD_LEN + b] = r_shd[c][CNT_W-1-b];
`ifdef SPECTRO_PARITY_EN
      w_stream[HDR_LEN + c*WORD_LEN + CNT_W] = ^r_shd[c];
`endif
    end
  end

  assign busy         = (r_state != IDLE);
  assign serial_valid = busy;
  assign serial_out   = busy & w_stream[r_bit];
  assign frame_start  = r_fs;
  assign ovf_flag     = r_ovf;
  assign overrun      = r_ovr;

endmodule
